// File: rtl/drv_display_scan.sv
// drv_display_scan: multiplexed N-digit 7-segment scanner.
// Refresh prescaler, anti-ghost blanking, PWM brightness, tear-free frame updates.
//
// Ports:
//   clk        in  system clock, rising edge
//   rst_n      in  asynchronous reset, active-low
//   digits     in  packed 5-bit codes, digit i = digits[5*i+4:5*i], digit 0 rightmost
//   load       in  capture digits into the pending register
//   brillo     in  brightness, 0 = dimmest, all-ones = full
//   enable     out one-hot digit select (inverted when EN_ACT_LOW=1)
//   segmentos  out [6]=a .. [0]=g (inverted when SEG_ACT_LOW=1)
//   frame_done out 1-clock pulse at the end of each full scan
//
// Codes: 0x00-0x0F hex glyphs, 0x11 minus, everything else blank.
// Optional build macro LZ_SUPPRESS_EN: blank leading zeros (digit 0 never blanked).

module drv_display_scan #(
    parameter int N_DIG       = 4,
    parameter int CLK_DIV     = 50000,
    parameter int PWM_BITS    = 3,
    parameter int BLANK_CYC   = 2,
    parameter int SEG_ACT_LOW = 0,
    parameter int EN_ACT_LOW  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5*N_DIG-1:0]    digits,
    input  logic                  load,
    input  logic [PWM_BITS-1:0]   brillo,
    output logic [N_DIG-1:0]      enable,
    output logic [6:0]            segmentos,
    output logic                  frame_done
);

    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [PW-1:0] LAST_P = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] STEP   = PW'(CLK_DIV >> PWM_BITS);
    localparam logic [PW-1:0] BLANK  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] LAST_I = IW'(N_DIG - 1);

    localparam logic [5*N_DIG-1:0] ALL_BLANK = {N_DIG{5'h10}};

    logic [PW-1:0]             r_presc;
    logic [IW-1:0]             r_idx;
    logic [N_DIG-1:0][4:0]     r_pending;
    logic [N_DIG-1:0][4:0]     r_active;
    logic [PWM_BITS-1:0]       r_br_q;
    logic [N_DIG-1:0]          r_enable;
    logic [6:0]                r_seg;
    logic                      r_frame_done;

    logic                      w_slot_end;
    logic                      w_frame_end;
    logic [PWM_BITS-1:0]       w_br;
    logic [PW-1:0]             w_brp1;
    logic [PW-1:0]             w_on;
    logic                      w_lit;
    logic [4:0]                w_code;
    logic [4:0]                w_code_eff;
    logic [N_DIG-1:0]          w_sup;
    logic [N_DIG-1:0]          w_en_nxt;

    function automatic logic [6:0] f_glyph(input logic [4:0] c);
        logic [6:0] g;
        case (c)
            5'h00:   g = 7'h7E;
            5'h01:   g = 7'h30;
            5'h02:   g = 7'h6D;
            5'h03:   g = 7'h79;
            5'h04:   g = 7'h33;
            5'h05:   g = 7'h5B;
            5'h06:   g = 7'h5F;
            5'h07:   g = 7'h70;
            5'h08:   g = 7'h7F;
            5'h09:   g = 7'h7B;
            5'h0A:   g = 7'h77;
            5'h0B:   g = 7'h1F;
            5'h0C:   g = 7'h4E;
            5'h0D:   g = 7'h3D;
            5'h0E:   g = 7'h4F;
            5'h0F:   g = 7'h47;
            5'h11:   g = 7'h01;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    assign w_slot_end  = (r_presc == LAST_P);
    assign w_frame_end = w_slot_end && (r_idx == LAST_I);

    // Slot start uses the live input so the sample taken this cycle
    // already governs the whole slot.
    assign w_br   = (r_presc == '0) ? brillo : r_br_q;
    assign w_brp1 = PW'(w_br) + PW'(1);
    assign w_on   = w_brp1 * STEP;
    assign w_lit  = (r_presc >= BLANK) && (r_presc < w_on);

`ifdef LZ_SUPPRESS_EN
    always_comb begin
        logic v_run;
        v_run = 1'b1;
        w_sup = '0;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            if (v_run && (r_active[i] == 5'h00)) begin
                w_sup[i] = 1'b1;
            end else begin
                v_run = 1'b0;
            end
        end
    end
`else
    assign w_sup = '0;
`endif

    assign w_code     = r_active[r_idx];
    assign w_code_eff = w_sup[r_idx] ? 5'h10 : w_code;

    always_comb begin
        w_en_nxt = '0;
        if (w_lit) begin
            w_en_nxt[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_idx   <= (r_idx == LAST_I) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_q <= '0;
        end else if (r_presc == '0) begin
            r_br_q <= brillo;
        end
    end

    // A load in the boundary cycle goes straight to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= ALL_BLANK;
            r_active  <= ALL_BLANK;
        end else begin
            if (load) begin
                r_pending <= digits;
            end
            if (w_frame_end) begin
                r_active <= load ? digits : r_pending;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable     <= '0;
            r_seg        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_enable     <= w_en_nxt;
            r_seg        <= f_glyph(w_code_eff);
            r_frame_done <= w_frame_end;
        end
    end

    assign enable     = (EN_ACT_LOW  != 0) ? ~r_enable : r_enable;
    assign segmentos  = (SEG_ACT_LOW != 0) ? ~r_seg    : r_seg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_drv_display_scan.sv
// tb_drv_display_scan: directed self-checking bench for drv_display_scan.
// N_DIG=3, CLK_DIV=16, PWM_BITS=3, BLANK_CYC=2, active-high outputs.

module tb_drv_display_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] digits = '0;
    logic        load = 1'b0;
    logic [2:0]  brillo = 3'd7;
    logic [2:0]  enable;
    logic [6:0]  segmentos;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    drv_display_scan #(
        .N_DIG      (3),
        .CLK_DIV    (16),
        .PWM_BITS   (3),
        .BLANK_CYC  (2),
        .SEG_ACT_LOW(0),
        .EN_ACT_LOW (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .load       (load),
        .brillo     (brillo),
        .enable     (enable),
        .segmentos  (segmentos),
        .frame_done (frame_done)
    );

    // Wait for a frame_done sample; afterwards the next negedge shows slot 0, presc 0.
    task automatic align();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_done !== 1'b1 && k < 200);
        vectors++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL align: frame_done=%b after %0d cycles, required 1", frame_done, k);
        end
    endtask

    // Check one aligned frame of 48 samples. Sample j shows slot j/16, presc j%16.
    task automatic capture(
        input string       nm,
        input logic [6:0]  g0, input logic [6:0] g1, input logic [6:0] g2,
        input int          hi0, input int hi1, input int hi2,
        input int          chg_at, input logic [2:0] chg_br,
        input int          ld_at, input logic [14:0] ld_val
    );
        logic [6:0] g [3];
        int         hi [3];
        int         s, p;
        logic [2:0] exp_en;
        logic       exp_fd;
        g[0] = g0; g[1] = g1; g[2] = g2;
        hi[0] = hi0; hi[1] = hi1; hi[2] = hi2;
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            s = j / 16;
            p = j % 16;
            exp_en = '0;
            if (p >= 2 && p <= hi[s]) exp_en[s] = 1'b1;
            exp_fd = (j == 47);
            vectors++;
            if (enable !== exp_en) begin
                errors++;
                $display("FAIL %s enable j=%0d: got %b, required %b", nm, j, enable, exp_en);
            end
            vectors++;
            if (segmentos !== g[s]) begin
                errors++;
                $display("FAIL %s segmentos j=%0d: got %b, required %b", nm, j, segmentos, g[s]);
            end
            vectors++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL %s frame_done j=%0d: got %b, required %b", nm, j, frame_done, exp_fd);
            end
            if (j == chg_at) brillo = chg_br;
            if (j == ld_at) begin
                load   = 1'b1;
                digits = ld_val;
            end
            if (j == ld_at + 1) load = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        brillo = 3'd7;
        digits = {5'h0E, 5'h03, 5'h01};
        load   = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (enable !== 3'b000) begin
            errors++;
            $display("FAIL reset enable: got %b, required 000", enable);
        end
        vectors++;
        if (segmentos !== 7'h00) begin
            errors++;
            $display("FAIL reset segmentos: got %b, required 0000000", segmentos);
        end
        vectors++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset frame_done: got %b, required 0", frame_done);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 47; j++) begin
            @(negedge clk);
            load = 1'b0;
            vectors++;
            if (segmentos !== 7'h00) begin
                errors++;
                $display("FAIL first_frame segmentos j=%0d: got %b, required 0000000", j, segmentos);
            end
        end
        align();
    endtask

    task automatic test_scan();
        capture("scan", 7'h30, 7'h79, 7'h4F, 15, 15, 15, -1, 3'd0, -1, '0);
    endtask

    task automatic test_brightness();
        brillo = 3'd0;
        capture("br0", 7'h30, 7'h79, 7'h4F, 1, 1, 1, -1, 3'd0, -1, '0);
        brillo = 3'd3;
        capture("br3", 7'h30, 7'h79, 7'h4F, 7, 7, 7, -1, 3'd0, -1, '0);
        brillo = 3'd7;
        capture("br_mid", 7'h30, 7'h79, 7'h4F, 15, 7, 7, 5, 3'd3, -1, '0);
        brillo = 3'd7;
    endtask

    task automatic test_tear_free();
        capture("tear_cur", 7'h30, 7'h79, 7'h4F, 15, 15, 15,
                -1, 3'd0, 20, {5'h09, 5'h0A, 5'h0D});
        capture("tear_next", 7'h3D, 7'h77, 7'h7B, 15, 15, 15,
                -1, 3'd0, 46, {5'h11, 5'h08, 5'h0F});
        capture("boundary_ld", 7'h47, 7'h7F, 7'h01, 15, 15, 15,
                -1, 3'd0, 46, {5'h00, 5'h00, 5'h00});
    endtask

    task automatic test_leading_zero();
`ifdef LZ_SUPPRESS_EN
        capture("lz_000", 7'h7E, 7'h00, 7'h00, 15, 15, 15,
                -1, 3'd0, 46, {5'h00, 5'h11, 5'h00});
        capture("lz_0m0", 7'h7E, 7'h01, 7'h00, 15, 15, 15,
                -1, 3'd0, -1, '0);
`else
        capture("lz_000", 7'h7E, 7'h7E, 7'h7E, 15, 15, 15,
                -1, 3'd0, 46, {5'h00, 5'h11, 5'h00});
        capture("lz_0m0", 7'h7E, 7'h01, 7'h7E, 15, 15, 15,
                -1, 3'd0, -1, '0);
`endif
    endtask

    task automatic test_async_reset();
        logic [2:0] exp_en;
        repeat (25) @(negedge clk);
        vectors++;
        if (enable !== 3'b010) begin
            errors++;
            $display("FAIL pre_reset enable: got %b, required 010", enable);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (enable !== 3'b000) begin
            errors++;
            $display("FAIL async_reset enable: got %b, required 000", enable);
        end
        vectors++;
        if (segmentos !== 7'h00) begin
            errors++;
            $display("FAIL async_reset segmentos: got %b, required 0000000", segmentos);
        end
        vectors++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset frame_done: got %b, required 0", frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            exp_en = (j >= 2) ? 3'b001 : 3'b000;
            vectors++;
            if (enable !== exp_en) begin
                errors++;
                $display("FAIL restart enable j=%0d: got %b, required %b", j, enable, exp_en);
            end
            vectors++;
            if (segmentos !== 7'h00) begin
                errors++;
                $display("FAIL restart segmentos j=%0d: got %b, required 0000000", j, segmentos);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_brightness();
        test_tear_free();
        test_leading_zero();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
